ws2812b_rx_decoder: RTL and testbench
=====================================

Name: ws2812b_rx_decoder

Overview:
Receive-side counterpart of the team's WS2812B meter transmitter. It samples a single-wire WS2812B data stream, times each high pulse to recover data bits, and assembles MSB-first 24-bit pixel words. It detects the >=50us low reset gap as end-of-frame and flags malformed pulses. It is used for loopback checking of the meter output on-board and for capturing external LED streams.

Parameters:
CLK_PERIOD_NS, 10, system clock period in ns (100MHz)
T_MIN_HIGH_NS, 200, shorter high pulse is a glitch (error)
T_THRESH_NS, 600, high pulse >= this decodes as 1, shorter decodes as 0
T_MAX_HIGH_NS, 1200, longer high pulse is an error
T_RESET_NS, 50000, low time that ends a frame
Derived cycle counts: value_ns/CLK_PERIOD_NS, truncated. At defaults: MIN=20, THR=60, MAX=120, RST=5000. Counter width is $clog2(RST+1), minimum 16.

Ports:
clk  in  1  system clock, rising edge
reset_n  in  1  asynchronous active-low reset
enable  in  1  decoder enable
DIN  in  1  asynchronous WS2812B serial input
pixel_data  out  24  last decoded pixel, bit 23 first received
pixel_valid  out  1  one-cycle strobe; pixel_data and pixel_index are valid
pixel_index  out  16  0-based pixel position within the frame
frame_done  out  1  one-cycle strobe at the reset gap
frame_pixels  out  16  pixels completed in the frame; valid with frame_done
bit_error  out  1  one-cycle strobe on a protocol violation
busy  out  1  high while in RUN with bit_cnt != 0 or DIN high

Behaviour:
- Interface: one clock (clk). Reset is asynchronous, active-low (reset_n). All flops clear on reset.
- Reset values: all outputs 0; state SYNC; all counters 0.
- DIN passes through a 2-FF synchronizer (din_s), then a delay flop (din_q). rise = din_s & ~din_q; fall = ~din_s & din_q. All timing uses din_s.
- States:
  - SYNC: wait for a clean reset gap. Low counter runs while din_s=0 and clears on din_s=1. Reaching RST -> RUN. No outputs are produced. Entered from reset, after any error, and whenever enable=0.
  - RUN: line low between bits. Low counter increments. Reaching RST with pixel_cnt>0 or bit_cnt>0 pulses frame_done with frame_pixels=pixel_cnt, then clears pixel_cnt and bit_cnt. If bit_cnt!=0 at that point, bit_error also pulses in the same cycle and the partial pixel is discarded. A gap with no data produces no strobe. rise -> HIGH with high counter set to 1 and low counter cleared.
  - HIGH: high counter increments, saturating at MAX+1. Reaching MAX+1 -> bit_error, go to SYNC. On fall, classify the high count: <MIN -> bit_error, go to SYNC; <THR -> bit 0; otherwise bit 1. The bit shifts into shreg LSB-first-in (MSB of the pixel is received first), bit_cnt+1, state -> RUN.
- On the 24th bit (bit_cnt 23->0), the next clock registers pixel_data = completed word, pixel_index = pixel_cnt, and pixel_valid=1 for exactly one cycle. pixel_cnt then increments, saturating at 0xFFFF.
- Latency: pixel_valid rises 4 clk edges after the DIN falling edge of the last bit (2 sync, 1 edge detect, 1 output register).
- pixel_data holds its value until the next pixel. frame_pixels holds until the next frame_done.
- enable=0 has priority over all transitions: go to SYNC next cycle, discard partial data, emit no strobes. Deasserting enable mid-pixel emits no error.
- Simultaneous events: frame_done and bit_error may pulse in the same cycle. pixel_valid and frame_done cannot coincide, because a reset gap needs a low time of at least RST cycles.
- Reset mid-frame: all state discarded. The block returns to SYNC and requires a full gap before decoding.

Decomposition:
- Package ws2812b_pkg holds the ns timing constants (T0H/T0L/T1H/T1L/RESET), the shared ns-to-cycle conversion function, and the state enum for SYNC/RUN/HIGH.
- Sub-module ws2812b_din_sync: 2-FF synchronizer, delay flop, and rise/fall edge outputs.

Test Plan:
1. DIN low for 6000 cycles, then pixel 0xA50F3C (0: 40H/85L cycles, 1: 80H/45L) -> one pixel_valid, pixel_data=0xA50F3C, pixel_index=0, busy=0 afterwards.
2. Pixels 0x123456 and 0xFFFFFF, then 10000 cycles low -> indices 0 and 1; one frame_done with frame_pixels=2, 5000 cycles after the last falling edge plus sync latency.
3. In RUN, a 10-cycle high glitch -> bit_error. Following bits give no pixel_valid until a 5000-cycle low; the next pixel decodes correctly.
4. High held 150 cycles -> bit_error at high count 121. Also a 12-bit partial pixel followed by a gap -> frame_done (frame_pixels=0) and bit_error in the same cycle.
5. Boundaries: high of 59 cycles -> 0, 60 -> 1, 19 -> error, 20 -> 0, 120 -> 1. Low of 4999 cycles does not end the frame.
6. enable dropped at bit 10 and reset_n pulsed mid-pixel -> no strobes. Decoding resumes only after a full gap.

Source files
------------

// File: rtl/ws2812b_pkg.sv
// WS2812B line timing in ns, the ns-to-cycle conversion and the decoder state type.
package ws2812b_pkg;

    localparam int T0H_NS   = 400;
    localparam int T0L_NS   = 850;
    localparam int T1H_NS   = 800;
    localparam int T1L_NS   = 450;
    localparam int RESET_NS = 50000;

    typedef enum logic [1:0] {
        SYNC = 2'd0,
        RUN  = 2'd1,
        HIGH = 2'd2
    } rxState_t;

    // Truncating conversion; callers pick thresholds knowing this rounds down.
    function automatic int nsToCycles(input int ns, input int periodNs);
        return ns / periodNs;
    endfunction

endpackage

// File: rtl/ws2812b_din_sync.sv
// Brings the asynchronous WS2812B line into clk and flags its rising and falling edges.
module ws2812b_din_sync (
    input  logic clk,
    input  logic reset_n,
    input  logic din,
    output logic dinS,
    output logic rise,
    output logic fall
);

    logic meta;
    logic dinQ;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            meta <= 1'b0;
            dinS <= 1'b0;
            dinQ <= 1'b0;
        end else begin
            meta <= din;
            dinS <= meta;
            dinQ <= dinS;
        end
    end

    assign rise = dinS & ~dinQ;
    assign fall = ~dinS & dinQ;

endmodule

// File: rtl/ws2812b_rx_decoder.sv
// Times WS2812B high pulses into bits, assembles MSB-first 24-bit pixels and
// detects the low reset gap that ends a frame.
//   state | meaning
//   SYNC  | waiting for a full low gap before trusting the line
//   RUN   | line low between bits, low time is being measured
//   HIGH  | line high, pulse width is being measured
module ws2812b_rx_decoder
    import ws2812b_pkg::*;
#(
    parameter int CLK_PERIOD_NS = 10,
    parameter int T_MIN_HIGH_NS = T0H_NS / 2,
    parameter int T_THRESH_NS   = (T0H_NS + T1H_NS) / 2,
    parameter int T_MAX_HIGH_NS = T0H_NS + T1H_NS,
    parameter int T_RESET_NS    = RESET_NS
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        enable,
    input  logic        DIN,
    output logic [23:0] pixel_data,
    output logic        pixel_valid,
    output logic [15:0] pixel_index,
    output logic        frame_done,
    output logic [15:0] frame_pixels,
    output logic        bit_error,
    output logic        busy
);

    localparam int MIN_CYC = nsToCycles(T_MIN_HIGH_NS, CLK_PERIOD_NS);
    localparam int THR_CYC = nsToCycles(T_THRESH_NS, CLK_PERIOD_NS);
    localparam int MAX_CYC = nsToCycles(T_MAX_HIGH_NS, CLK_PERIOD_NS);
    localparam int RST_CYC = nsToCycles(T_RESET_NS, CLK_PERIOD_NS);
    localparam int CNT_W   = ($clog2(RST_CYC + 1) > 16) ? $clog2(RST_CYC + 1) : 16;

    localparam logic [CNT_W-1:0] ONE_C  = CNT_W'(1);
    localparam logic [CNT_W-1:0] MIN_C  = CNT_W'(MIN_CYC);
    localparam logic [CNT_W-1:0] THR_C  = CNT_W'(THR_CYC);
    localparam logic [CNT_W-1:0] MAX_C  = CNT_W'(MAX_CYC);
    localparam logic [CNT_W-1:0] SAT_C  = CNT_W'(MAX_CYC + 1);
    localparam logic [CNT_W-1:0] RST_C  = CNT_W'(RST_CYC);
    localparam logic [CNT_W-1:0] RST_M1 = CNT_W'(RST_CYC - 1);

    logic dinS;
    logic rise;
    logic fall;

    rxState_t         state;
    logic [CNT_W-1:0] lowCnt;
    logic [CNT_W-1:0] highCnt;
    logic [4:0]       bitCnt;
    logic [15:0]      pixelCnt;
    logic [23:0]      shreg;
    logic             pixelDone;

    ws2812b_din_sync u_din_sync (
        .clk     (clk),
        .reset_n (reset_n),
        .din     (DIN),
        .dinS    (dinS),
        .rise    (rise),
        .fall    (fall)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= SYNC;
            lowCnt       <= '0;
            highCnt      <= '0;
            bitCnt       <= '0;
            pixelCnt     <= '0;
            shreg        <= '0;
            pixelDone    <= 1'b0;
            pixel_data   <= '0;
            pixel_valid  <= 1'b0;
            pixel_index  <= '0;
            frame_done   <= 1'b0;
            frame_pixels <= '0;
            bit_error    <= 1'b0;
        end else begin
            pixel_valid <= 1'b0;
            frame_done  <= 1'b0;
            bit_error   <= 1'b0;
            pixelDone   <= 1'b0;
            if (!enable) begin
                state    <= SYNC;
                lowCnt   <= '0;
                highCnt  <= '0;
                bitCnt   <= '0;
                pixelCnt <= '0;
            end else begin
                if (pixelDone) begin
                    pixel_data  <= shreg;
                    pixel_index <= pixelCnt;
                    pixel_valid <= 1'b1;
                    if (pixelCnt != 16'hFFFF) pixelCnt <= pixelCnt + 16'd1;
                end
                case (state)
                    SYNC: begin
                        bitCnt   <= '0;
                        pixelCnt <= '0;
                        if (dinS) begin
                            lowCnt <= '0;
                        end else if (lowCnt == RST_M1) begin
                            lowCnt <= RST_C;
                            state  <= RUN;
                        end else begin
                            lowCnt <= lowCnt + ONE_C;
                        end
                    end
                    RUN: begin
                        if (rise) begin
                            state   <= HIGH;
                            highCnt <= ONE_C;
                            lowCnt  <= '0;
                        end else if (lowCnt != RST_C) begin
                            lowCnt <= lowCnt + ONE_C;
                            // A gap with a partial pixel still closes the frame, but flags the loss.
                            if (lowCnt == RST_M1 && (pixelCnt != 16'd0 || bitCnt != 5'd0)) begin
                                frame_done   <= 1'b1;
                                frame_pixels <= pixelCnt;
                                bit_error    <= (bitCnt != 5'd0);
                                pixelCnt     <= '0;
                                bitCnt       <= '0;
                            end
                        end
                    end
                    HIGH: begin
                        if (fall) begin
                            lowCnt <= ONE_C;
                            if (highCnt < MIN_C) begin
                                bit_error <= 1'b1;
                                state     <= SYNC;
                                lowCnt    <= '0;
                            end else begin
                                shreg <= {shreg[22:0], (highCnt >= THR_C)};
                                state <= RUN;
                                if (bitCnt == 5'd23) begin
                                    bitCnt    <= '0;
                                    pixelDone <= 1'b1;
                                end else begin
                                    bitCnt <= bitCnt + 5'd1;
                                end
                            end
                        end else if (highCnt == MAX_C) begin
                            bit_error <= 1'b1;
                            highCnt   <= SAT_C;
                            lowCnt    <= '0;
                            state     <= SYNC;
                        end else begin
                            highCnt <= highCnt + ONE_C;
                        end
                    end
                    default: state <= SYNC;
                endcase
            end
        end
    end

    assign busy = (state == HIGH) || (state == RUN && bitCnt != 5'd0);

endmodule

// File: tb/tb_ws2812b_rx_decoder.sv
// Directed bench for ws2812b_rx_decoder with a scoreboard of expected pixels and frames.
module tb_ws2812b_rx_decoder;
    import ws2812b_pkg::*;

    localparam int T0H = nsToCycles(T0H_NS, 10);
    localparam int T0L = nsToCycles(T0L_NS, 10);
    localparam int T1H = nsToCycles(T1H_NS, 10);
    localparam int T1L = nsToCycles(T1L_NS, 10);
    localparam int GAP = 5050;
    localparam int FRAME_LAT = 5002;
    localparam int PIX_LAT = 4;

    typedef struct {
        logic [23:0] data;
        logic [15:0] idx;
        int          due;
    } pixExp_t;

    typedef struct {
        logic [15:0] n;
        logic        err;
        int          due;
    } frmExp_t;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        enable;
    logic        DIN;
    logic [23:0] pixel_data;
    logic        pixel_valid;
    logic [15:0] pixel_index;
    logic        frame_done;
    logic [15:0] frame_pixels;
    logic        bit_error;
    logic        busy;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int errCnt = 0;
    int errCyc = 0;
    int expErr = 0;
    int lastFall = 0;
    int riseCyc = 0;
    pixExp_t pixQ[$];
    frmExp_t frmQ[$];

    ws2812b_rx_decoder dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .enable       (enable),
        .DIN          (DIN),
        .pixel_data   (pixel_data),
        .pixel_valid  (pixel_valid),
        .pixel_index  (pixel_index),
        .frame_done   (frame_done),
        .frame_pixels (frame_pixels),
        .bit_error    (bit_error),
        .busy         (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        pixExp_t pe;
        frmExp_t fe;
        if (bit_error === 1'b1) begin
            errCnt++;
            errCyc = cyc;
        end
        if (pixel_valid === 1'b1) begin
            chk("pixel_expected", 32'(pixQ.size() != 0), 32'd1);
            if (pixQ.size() != 0) begin
                pe = pixQ.pop_front();
                chk("pixel_data", 32'(pixel_data), 32'(pe.data));
                chk("pixel_index", 32'(pixel_index), 32'(pe.idx));
                chk("pixel_latency", 32'(cyc), 32'(pe.due));
            end
        end
        if (frame_done === 1'b1) begin
            chk("frame_expected", 32'(frmQ.size() != 0), 32'd1);
            if (frmQ.size() != 0) begin
                fe = frmQ.pop_front();
                chk("frame_pixels", 32'(frame_pixels), 32'(fe.n));
                chk("frame_bit_error", 32'(bit_error), 32'(fe.err));
                chk("frame_latency", 32'(cyc), 32'(fe.due));
            end
        end
    end

    // Sends the low n bits of w MSB first; optionally expects a pixel after the last one.
    task automatic sendBits(input logic [23:0] w, input int n, input bit doPush,
                            input logic [23:0] expWord, input logic [15:0] idx, input int lastLow);
        for (int i = n - 1; i >= 0; i--) begin
            logic b;
            int h;
            int l;
            b = w[5'(i)];
            h = b ? T1H : T0H;
            l = (i == 0) ? lastLow : (b ? T1L : T0L);
            DIN = 1'b1;
            repeat (h) @(negedge clk);
            DIN = 1'b0;
            lastFall = cyc;
            if (i == 0 && doPush) pixQ.push_back('{expWord, idx, cyc + PIX_LAT});
            repeat (l) @(negedge clk);
        end
    endtask

    task automatic sendRaw(input int h, input int l);
        DIN = 1'b1;
        repeat (h) @(negedge clk);
        DIN = 1'b0;
        lastFall = cyc;
        repeat (l) @(negedge clk);
    endtask

    initial begin
        reset_n = 1'b0;
        enable  = 1'b0;
        DIN     = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_pixel_data", 32'(pixel_data), 32'h0);
        chk("rst_pixel_valid", 32'(pixel_valid), 32'h0);
        chk("rst_pixel_index", 32'(pixel_index), 32'h0);
        chk("rst_frame_done", 32'(frame_done), 32'h0);
        chk("rst_frame_pixels", 32'(frame_pixels), 32'h0);
        chk("rst_bit_error", 32'(bit_error), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        reset_n = 1'b1;
        enable  = 1'b1;
        repeat (GAP) @(negedge clk);

        // single pixel, then its frame
        sendBits(24'hA50F3C, 24, 1'b1, 24'hA50F3C, 16'd0, T0L);
        repeat (20) @(negedge clk);
        chk("busy_idle", 32'(busy), 32'h0);
        chk("pixel_hold", 32'(pixel_data), 32'hA50F3C);
        frmQ.push_back('{16'd1, 1'b0, lastFall + FRAME_LAT});
        repeat (GAP) @(negedge clk);

        // two pixels, long gap
        sendBits(24'h123456, 24, 1'b1, 24'h123456, 16'd0, T0L);
        sendBits(24'hFFFFFF, 24, 1'b1, 24'hFFFFFF, 16'd1, T1L);
        frmQ.push_back('{16'd2, 1'b0, lastFall + FRAME_LAT});
        repeat (10000) @(negedge clk);
        chk("frame_pixels_hold", 32'(frame_pixels), 32'd2);

        // partial pixel closed by a gap
        sendBits(24'h000ABC, 12, 1'b0, 24'h0, 16'd0, T0L);
        frmQ.push_back('{16'd0, 1'b1, lastFall + FRAME_LAT});
        expErr++;
        repeat (GAP) @(negedge clk);
        chk("err_partial", 32'(errCnt), 32'(expErr));

        // glitch, ignored bits until a full gap, then a clean pixel
        sendRaw(10, T0L);
        expErr++;
        chk("err_glitch", 32'(errCnt), 32'(expErr));
        sendBits(24'h00000F, 8, 1'b0, 24'h0, 16'd0, T0L);
        repeat (GAP) @(negedge clk);
        sendBits(24'hC3C3C3, 24, 1'b1, 24'hC3C3C3, 16'd0, T0L);

        // overlong high
        riseCyc = cyc;
        DIN = 1'b1;
        repeat (150) @(negedge clk);
        DIN = 1'b0;
        expErr++;
        repeat (20) @(negedge clk);
        chk("err_long_count", 32'(errCnt), 32'(expErr));
        chk("err_long_time", 32'(errCyc), 32'(riseCyc + 123));
        repeat (GAP) @(negedge clk);

        // width boundaries 59/60/20/120 give 0101, then a 4999-cycle low keeps the frame open
        sendRaw(59, T0L);
        sendRaw(60, T1L);
        sendRaw(20, T0L);
        sendRaw(120, T1L);
        sendBits(24'h0ABCDE, 20, 1'b1, 24'h5ABCDE, 16'd0, 4999);
        sendBits(24'h3C3C3C, 24, 1'b1, 24'h3C3C3C, 16'd1, T0L);
        sendRaw(19, T0L);
        expErr++;
        chk("err_min_edge", 32'(errCnt), 32'(expErr));
        repeat (GAP) @(negedge clk);

        // enable drop and reset mid-pixel discard everything until a full gap
        sendBits(24'h0002AA, 10, 1'b0, 24'h0, 16'd0, T0L);
        enable = 1'b0;
        sendBits(24'h00000A, 4, 1'b0, 24'h0, 16'd0, T0L);
        enable = 1'b1;
        sendBits(24'h000005, 4, 1'b0, 24'h0, 16'd0, T0L);
        reset_n = 1'b0;
        @(negedge clk);
        chk("midrst_pixel_data", 32'(pixel_data), 32'h0);
        chk("midrst_pixel_index", 32'(pixel_index), 32'h0);
        @(negedge clk);
        reset_n = 1'b1;
        sendBits(24'h00002D, 6, 1'b0, 24'h0, 16'd0, T0L);
        repeat (GAP) @(negedge clk);
        sendBits(24'h00FF00, 24, 1'b1, 24'h00FF00, 16'd0, T0L);
        repeat (20) @(negedge clk);

        chk("err_total", 32'(errCnt), 32'(expErr));
        chk("pixel_q_drained", 32'(pixQ.size()), 32'd0);
        chk("frame_q_drained", 32'(frmQ.size()), 32'd0);
        chk("final_pixel_hold", 32'(pixel_data), 32'h00FF00);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
